nmos_lp_latch_bank: RTL and testbench
=====================================

Name: nmos_lp_latch_bank

Overview:
Parametrised multi-channel light-pen latch bank, the next generation of the single NMOS light-pen latch.
- Each of NCH channels captures a DW-bit position word (e.g. beam X/Y) when its trigger fires.
- Captured words are read back through a shared tri-state-style data bus with pass-through when not reading the latch.
- Adds edge-triggered capture, once-per-frame arming, per-channel valid flags with clear-on-read, and an interrupt output.

Parameters:
DW, 8, data width of each captured word and of the bus
NCH, 2, number of latch channels (1..16)
AW, derived as max(1, clog2(NCH)), read-select width (localparam, not overridable)
EDGE, 1, 1 = capture on rising edge of lp_ld; 0 = level load on every cycle lp_ld is high (legacy NMOS behaviour)
ONESHOT, 1, 1 = at most one capture per channel per frame; 0 = every trigger captures

Ports:
main_clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
lp_ld  in  NCH  per-channel capture trigger
frame_rst  in  1  single-cycle pulse re-arming all channels
di  in  NCH*DW  per-channel capture data; channel k in bits [k*DW +: DW]
lp_rd  in  1  1 = bus sources latched word; 0 = bus sources live di
rd_sel  in  AW  channel selected for bus read
oe  in  1  bus output enable
db_i  in  DW  external bus value (input half of inout pad)
db_o  out  DW  bus drive value
db_oe  out  1  bus drive enable (pad tri-states when 0)
dout  out  DW  bus readback: oe ? db_o : db_i
valid  out  NCH  per-channel "captured, not yet read" flag
irq  out  1  OR of valid

Behaviour:
Reset (rst = 1 at a clock edge):
- all latch registers = 0, valid = 0, armed = all 1, lp_ld history = 0.
- Outputs after reset: valid = 0, irq = 0. db_oe, db_o and dout remain combinational.

Trigger per channel k:
- trig[k] = EDGE ? (lp_ld[k] & ~lp_ld_q[k]) : lp_ld[k].
- lp_ld_q is lp_ld registered on main_clk.
- lp_ld is already synchronous to main_clk; the block adds no synchroniser.

Capture:
- Condition: trig[k] & armed[k] at a clock edge.
- Effect: lat[k] <= di[k], valid[k] <= 1. If ONESHOT = 1, also armed[k] <= 0.
- Latency: the captured word is readable on the bus, and valid/irq are high, in the cycle after the capturing edge.

Re-arm:
- frame_rst = 1 sets armed to all 1 at the next edge; latched data and valid are untouched.
- frame_rst and a trigger at the same edge: the capture occurs and armed[k] stays 1 (frame_rst wins for arm).

Bus path (combinational):
- sel_lat = lat[rd_sel]; sel_di = di slice rd_sel.
- rd_sel >= NCH selects an all-zero word.
- db_o = lp_rd ? sel_lat : sel_di; db_oe = oe.

Clear-on-read:
- At an edge with oe & lp_rd & (rd_sel == k), valid[k] <= 0.
- A capture on the same channel at the same edge wins: valid stays 1 and lat takes the new data.
- Reading never changes lat or armed.

Other rules:
- ONESHOT = 0: every trig overwrites lat; valid is set again regardless of whether the previous word was read (no overflow flag).
- Reset mid-capture or mid-read: reset dominates all other updates at that edge.

Test Plan:
1. Reset, NCH=2, DW=8, EDGE=1, ONESHOT=1. Set di ch0 = 0x5A. Pulse lp_ld[0] for 3 cycles -> exactly one capture; lat0 = 0x5A; valid = 01b and irq = 1 the cycle after the rising edge.
2. Then di ch0 = 0x33 and a second lp_ld[0] edge -> no capture; reading with oe=1, lp_rd=1, rd_sel=0 gives db_o = dout = 0x5A and valid[0] clears the next cycle. Pulse frame_rst, then a third edge -> lat0 = 0x33.
3. Same edge has lp_ld[1] rising (di ch1 = 0xC3) and frame_rst = 1 -> lat1 = 0xC3, valid[1] = 1. A further edge with no frame_rst captures again, because armed stayed set.
4. Same edge has a read of ch1 and a new ch1 capture of 0x11 -> valid[1] remains 1, lat1 = 0x11.
5. Bus muxing: oe=0 with db_i = 0xE7 -> db_oe = 0, dout = 0xE7. oe=1, lp_rd=0, rd_sel=1, di ch1 = 0x42 -> db_o = dout = 0x42. NCH=3 with rd_sel=3 -> db_o = 0x00.
6. EDGE=0, ONESHOT=0: hold lp_ld[0] high while di ch0 counts 0,1,2 -> lat0 tracks with 1-cycle latency. Assert rst mid-sequence -> lat0 = 0, valid = 0, irq = 0 next cycle.

Source files
------------

// File: rtl/nmos_lp_latch_bank.sv
// Multi-channel light-pen latch bank: per-channel capture of a position word on a
// trigger, once-per-frame arming, clear-on-read valid flags and a shared readback bus.
module nmos_lp_latch_bank #(
  parameter int DW      = 8,
  parameter int NCH     = 2,
  parameter int EDGE    = 1,
  parameter int ONESHOT = 1
) (
  input  logic                  main_clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        lp_ld,
  input  logic                  frame_rst,
  input  logic [NCH*DW-1:0]     di,
  input  logic                  lp_rd,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_sel,
  input  logic                  oe,
  input  logic [DW-1:0]         db_i,
  output logic [DW-1:0]         db_o,
  output logic                  db_oe,
  output logic [DW-1:0]         dout,
  output logic [NCH-1:0]        valid,
  output logic                  irq
);

  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DW-1:0]  lat_reg [NCH];
  logic [NCH-1:0] lp_ld_q_reg;
  logic [NCH-1:0] armed_reg;
  logic [NCH-1:0] valid_reg;

  logic [NCH-1:0] trig;
  logic [NCH-1:0] cap;
  logic [NCH-1:0] rd_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi = gi + 1) begin : g_ch
      if (EDGE != 0) begin : g_edge
        assign trig[gi] = lp_ld[gi] & ~lp_ld_q_reg[gi];
      end else begin : g_level
        assign trig[gi] = lp_ld[gi];
      end
      assign cap[gi]    = trig[gi] & armed_reg[gi];
      assign rd_hit[gi] = oe & lp_rd & (rd_sel == AW'(gi));
    end
  endgenerate

  // Capture beats clear-on-read for valid; frame_rst beats one-shot disarm.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      lp_ld_q_reg <= '0;
      armed_reg   <= '1;
      valid_reg   <= '0;
      for (int k = 0; k < NCH; k++) lat_reg[k] <= '0;
    end else begin
      lp_ld_q_reg <= lp_ld;
      for (int k = 0; k < NCH; k++) begin
        if (cap[k]) begin
          lat_reg[k]   <= di[k*DW +: DW];
          valid_reg[k] <= 1'b1;
        end else if (rd_hit[k]) begin
          valid_reg[k] <= 1'b0;
        end
        if (frame_rst)
          armed_reg[k] <= 1'b1;
        else if (cap[k] && (ONESHOT != 0))
          armed_reg[k] <= 1'b0;
      end
    end
  end

  logic [DW-1:0] sel_lat;
  logic [DW-1:0] sel_di;

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    sel_lat = '0;
    sel_di  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_sel == AW'(k)) begin
        sel_lat = lat_reg[k];
        sel_di  = di[k*DW +: DW];
      end
    end
  end

  assign db_o  = lp_rd ? sel_lat : sel_di;
  assign db_oe = oe;
  assign dout  = oe ? db_o : db_i;
  assign valid = valid_reg;
  assign irq   = |valid_reg;

endmodule

// File: tb/tb_nmos_lp_latch_bank.sv
// Directed bench: one edge/one-shot 2-channel bank and one level/free-running 3-channel bank.
module tb_nmos_lp_latch_bank;

  logic main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: NCH=2, EDGE=1, ONESHOT=1
  logic        a_rst, a_frame_rst, a_lp_rd, a_oe;
  logic [1:0]  a_lp_ld;
  logic [15:0] a_di;
  logic [0:0]  a_rd_sel;
  logic [7:0]  a_db_i, a_db_o, a_dout;
  logic        a_db_oe, a_irq;
  logic [1:0]  a_valid;

  nmos_lp_latch_bank #(.DW(8), .NCH(2), .EDGE(1), .ONESHOT(1)) u_a (
    .main_clk(main_clk), .rst(a_rst), .lp_ld(a_lp_ld), .frame_rst(a_frame_rst),
    .di(a_di), .lp_rd(a_lp_rd), .rd_sel(a_rd_sel), .oe(a_oe), .db_i(a_db_i),
    .db_o(a_db_o), .db_oe(a_db_oe), .dout(a_dout), .valid(a_valid), .irq(a_irq)
  );

  // Instance B: NCH=3, EDGE=0, ONESHOT=0
  logic        b_rst, b_frame_rst, b_lp_rd, b_oe;
  logic [2:0]  b_lp_ld;
  logic [23:0] b_di;
  logic [1:0]  b_rd_sel;
  logic [7:0]  b_db_i, b_db_o, b_dout;
  logic        b_db_oe, b_irq;
  logic [2:0]  b_valid;

  nmos_lp_latch_bank #(.DW(8), .NCH(3), .EDGE(0), .ONESHOT(0)) u_b (
    .main_clk(main_clk), .rst(b_rst), .lp_ld(b_lp_ld), .frame_rst(b_frame_rst),
    .di(b_di), .lp_rd(b_lp_rd), .rd_sel(b_rd_sel), .oe(b_oe), .db_i(b_db_i),
    .db_o(b_db_o), .db_oe(b_db_oe), .dout(b_dout), .valid(b_valid), .irq(b_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    a_rst = 1; a_frame_rst = 0; a_lp_rd = 0; a_oe = 0; a_lp_ld = 0; a_di = 0; a_rd_sel = 0; a_db_i = 0;
    b_rst = 1; b_frame_rst = 0; b_lp_rd = 0; b_oe = 0; b_lp_ld = 0; b_di = 0; b_rd_sel = 0; b_db_i = 0;
    tick(); tick();
    a_rst = 0; b_rst = 0;
    settle();
    check("a_reset_valid", a_valid, 2'b00);
    check("a_reset_irq", a_irq, 1'b0);
    check("b_reset_valid", b_valid, 3'b000);

    // 1: held trigger captures only on its rising edge
    a_di[7:0] = 8'h5A; a_lp_ld[0] = 1'b1;
    tick();
    check("t1_valid", a_valid, 2'b01);
    check("t1_irq", a_irq, 1'b1);
    a_di[7:0] = 8'h77;
    tick(); tick();
    a_lp_ld[0] = 1'b0;
    a_lp_rd = 1; a_rd_sel = 0;
    settle();
    check("t1_lat0_once", a_db_o, 8'h5A);
    check("t1_db_oe_off", a_db_oe, 1'b0);

    // 2: disarmed edge ignored, read clears valid, frame_rst re-arms
    tick();
    a_di[7:0] = 8'h33; a_lp_ld[0] = 1'b1;
    tick();
    a_lp_ld[0] = 1'b0;
    settle();
    check("t2_no_capture", a_db_o, 8'h5A);
    a_oe = 1;
    settle();
    check("t2_dout_read", a_dout, 8'h5A);
    check("t2_db_oe_on", a_db_oe, 1'b1);
    tick();
    a_oe = 0;
    settle();
    check("t2_valid_cleared", a_valid, 2'b00);
    check("t2_irq_cleared", a_irq, 1'b0);
    a_frame_rst = 1;
    tick();
    a_frame_rst = 0; a_lp_ld[0] = 1'b1;
    tick();
    a_lp_ld[0] = 1'b0;
    settle();
    check("t2_rearm_valid", a_valid, 2'b01);
    check("t2_rearm_lat0", a_db_o, 8'h33);

    // 3: capture with simultaneous frame_rst leaves channel armed
    a_di[15:8] = 8'hC3; a_lp_ld[1] = 1'b1; a_frame_rst = 1;
    tick();
    a_frame_rst = 0; a_lp_ld[1] = 1'b0; a_rd_sel = 1;
    settle();
    check("t3_valid", a_valid, 2'b11);
    check("t3_lat1", a_db_o, 8'hC3);
    tick();
    a_di[15:8] = 8'h99; a_lp_ld[1] = 1'b1;
    tick();
    a_lp_ld[1] = 1'b0;
    settle();
    check("t3_still_armed", a_db_o, 8'h99);

    // 4: read and capture on the same channel at the same edge
    a_frame_rst = 1;
    tick();
    a_frame_rst = 0; a_oe = 1;
    tick();
    a_oe = 0;
    settle();
    check("t4_pre_clear", a_valid, 2'b01);
    a_oe = 1; a_di[15:8] = 8'h11; a_lp_ld[1] = 1'b1;
    tick();
    a_oe = 0; a_lp_ld[1] = 1'b0;
    settle();
    check("t4_valid_kept", a_valid, 2'b11);
    check("t4_lat1_new", a_db_o, 8'h11);

    // 5: bus muxing
    a_db_i = 8'hE7; a_oe = 0;
    settle();
    check("t5_db_oe_off", a_db_oe, 1'b0);
    check("t5_dout_pass", a_dout, 8'hE7);
    a_oe = 1; a_lp_rd = 0; a_rd_sel = 1; a_di[15:8] = 8'h42;
    settle();
    check("t5_db_o_live", a_db_o, 8'h42);
    check("t5_dout_live", a_dout, 8'h42);
    a_oe = 0;
    b_di = 24'hAB_CD_EF; b_rd_sel = 2'd3; b_lp_rd = 0;
    settle();
    check("t5_oob_live", b_db_o, 8'h00);
    b_lp_rd = 1;
    settle();
    check("t5_oob_lat", b_db_o, 8'h00);

    // 6: level load tracks di with one cycle of latency, then reset mid-sequence
    b_rd_sel = 0; b_di = 24'h0; b_lp_ld[0] = 1'b1;
    tick();
    check("t6_lat0_0", b_db_o, 8'h00);
    check("t6_valid", b_valid, 3'b001);
    b_di[7:0] = 8'h01;
    settle();
    check("t6_latency", b_db_o, 8'h00);
    tick();
    check("t6_lat0_1", b_db_o, 8'h01);
    b_di[7:0] = 8'h02;
    tick();
    check("t6_lat0_2", b_db_o, 8'h02);
    b_di[7:0] = 8'h05; b_rst = 1;
    tick();
    b_rst = 0; b_lp_ld = 0;
    settle();
    check("t6_rst_lat0", b_db_o, 8'h00);
    check("t6_rst_valid", b_valid, 3'b000);
    check("t6_rst_irq", b_irq, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
